// File: rtl/cordic_pkg.sv
// Shared constants for the vectoring CORDIC: widths, arctangent table and
// the fixed-point constants used by the quadrant and gain stages.
package cordic_pkg;

  localparam int unsigned ITER_DEF = 8;   // default micro-rotation count
  localparam int unsigned IW_DEF   = 12;  // default x/y/z width, Q3.8
  localparam int unsigned IN_W     = 8;   // Q1.7 input components
  localparam int unsigned ANG_W    = 9;   // Q3.6 angle
  localparam int unsigned MAG_W    = 9;   // Q2.7 magnitude

  // atan(2^-i) in Q3.8; entries past the useful precision are zero.
  localparam int unsigned ATAN_LEN = 16;
  localparam int ATAN [ATAN_LEN] = '{201, 119, 63, 32, 16, 8, 4, 2,
                                     1, 0, 0, 0, 0, 0, 0, 0};

  localparam int HALF_PI       = 402;  // pi/2 in Q3.8
  localparam int INV_GAIN      = 622;  // 1/K = 0.60725 in Q0.10
  localparam int INV_GAIN_FRAC = 10;
  localparam int PI_Q36        = 201;  // pi in Q3.6

  // Table lookup that stays in range for any stage count.
  function automatic int atan_q38(input int unsigned i);
    return (i < ATAN_LEN) ? ATAN[i] : 0;
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered vectoring micro-rotation; drives y toward zero while
// accumulating the rotated angle in z. The valid bit travels with the data.
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int unsigned STAGE = 0,
  parameter int unsigned IW    = IW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic signed [IW-1:0] i_x,
  input  logic signed [IW-1:0] i_y,
  input  logic signed [IW-1:0] i_z,
  output logic                 o_valid,
  output logic signed [IW-1:0] o_x,
  output logic signed [IW-1:0] o_y,
  output logic signed [IW-1:0] o_z
);

  localparam logic signed [IW-1:0] ATAN_I = IW'(atan_q38(STAGE));

  logic                 r_valid;
  logic signed [IW-1:0] r_x;
  logic signed [IW-1:0] r_y;
  logic signed [IW-1:0] r_z;
  logic signed [IW-1:0] w_x_sh;
  logic signed [IW-1:0] w_y_sh;

  assign w_x_sh = i_x >>> STAGE;
  assign w_y_sh = i_y >>> STAGE;

  // Rotate toward the x axis in the direction opposite to y's sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
    end
    if (!rst && i_valid) begin
      if (!i_y[IW-1]) begin
        r_x <= i_x + w_y_sh;
        r_y <= i_y - w_x_sh;
        r_z <= i_z + ATAN_I;
      end else begin
        r_x <= i_x - w_y_sh;
        r_y <= i_y + w_x_sh;
        r_z <= i_z - ATAN_I;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_z     = r_z;

endmodule

// File: rtl/cordic_vectoring.sv
// Fully pipelined vectoring-mode CORDIC: quadrant fold, ITER micro-rotations,
// then gain correction and rounding to Q3.6 angle / Q2.7 magnitude.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int unsigned ITER = ITER_DEF,
  parameter int unsigned IW   = IW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  x_in,
  input  logic signed [IN_W-1:0]  y_in,
  output logic                    out_valid,
  output logic signed [ANG_W-1:0] angle,
  output logic        [MAG_W-1:0] magnitude
);

  localparam int unsigned PW        = IW + INV_GAIN_FRAC + 2;
  localparam int unsigned MAG_SHIFT = INV_GAIN_FRAC + 1;   // Q3.18 -> Q2.7
  localparam int unsigned ANG_SHIFT = 2;                   // Q3.8  -> Q3.6

  localparam logic signed [IW-1:0] Z_HALF_PI  = IW'(HALF_PI);
  localparam logic signed [IW-1:0] ANG_HALF   = IW'(1 << (ANG_SHIFT - 1));
  localparam logic signed [IW-1:0] ANG_MAX    = IW'(PI_Q36);
  localparam logic signed [IW-1:0] ANG_MIN    = -ANG_MAX;
  localparam logic signed [PW-1:0] INV_GAIN_S = PW'(INV_GAIN);
  localparam logic signed [PW-1:0] MAG_HALF   = PW'(1 << (MAG_SHIFT - 1));
  localparam logic signed [PW-1:0] MAG_MAX    = PW'((1 << MAG_W) - 1);

  logic signed [IW-1:0] w_x_ext;
  logic signed [IW-1:0] w_y_ext;

  logic                 r_q_valid;
  logic signed [IW-1:0] r_q_x;
  logic signed [IW-1:0] r_q_y;
  logic signed [IW-1:0] r_q_z;

  logic [ITER:0]        w_valid;
  logic signed [IW-1:0] w_x [ITER+1];
  logic signed [IW-1:0] w_y [ITER+1];
  logic signed [IW-1:0] w_z [ITER+1];

  logic signed [PW-1:0]    w_prod;
  logic signed [PW-1:0]    w_mag_rnd;
  logic        [MAG_W-1:0] w_mag_sat;
  logic signed [IW-1:0]    w_ang_rnd;
  logic signed [IW-1:0]    w_ang_sat;
  logic                    w_zero;

  // Widen to Q3.8 before any negation so -128 folds without overflow.
  assign w_x_ext = IW'(x_in) <<< 1;
  assign w_y_ext = IW'(y_in) <<< 1;

  // Fold left-half-plane vectors into the right half plane by +/-90 degrees.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_valid <= 1'b0;
    end else begin
      r_q_valid <= in_valid;
    end
    if (!rst && in_valid) begin
      if (w_x_ext[IW-1] && !w_y_ext[IW-1]) begin
        r_q_x <= w_y_ext;
        r_q_y <= -w_x_ext;
        r_q_z <= Z_HALF_PI;
      end else if (w_x_ext[IW-1] && w_y_ext[IW-1]) begin
        r_q_x <= -w_y_ext;
        r_q_y <= w_x_ext;
        r_q_z <= -Z_HALF_PI;
      end else begin
        r_q_x <= w_x_ext;
        r_q_y <= w_y_ext;
        r_q_z <= '0;
      end
    end
  end

  assign w_valid[0] = r_q_valid;
  assign w_x[0]     = r_q_x;
  assign w_y[0]     = r_q_y;
  assign w_z[0]     = r_q_z;

  for (genvar g = 0; g < ITER; g++) begin : g_stage
    cordic_vec_stage #(
      .STAGE (g),
      .IW    (IW)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_valid[g]),
      .i_x     (w_x[g]),
      .i_y     (w_y[g]),
      .i_z     (w_z[g]),
      .o_valid (w_valid[g+1]),
      .o_x     (w_x[g+1]),
      .o_y     (w_y[g+1]),
      .o_z     (w_z[g+1])
    );
  end

  // x never decreases through the pipeline, so a zero final x means a
  // zero input vector, whose z would otherwise hold the table sum.
  assign w_zero    = (w_x[ITER] == '0);
  assign w_prod    = PW'(w_x[ITER]) * INV_GAIN_S;
  assign w_mag_rnd = (w_prod + MAG_HALF) >>> MAG_SHIFT;
  assign w_ang_rnd = (w_z[ITER] + ANG_HALF) >>> ANG_SHIFT;

  // Clamp the rounded magnitude and angle to their output ranges.
  always_comb begin
    w_mag_sat = w_mag_rnd[MAG_W-1:0];
    w_ang_sat = w_ang_rnd;
    if (w_mag_rnd[PW-1]) begin
      w_mag_sat = '0;
    end else if (w_mag_rnd > MAG_MAX) begin
      w_mag_sat = '1;
    end
    if (w_ang_rnd > ANG_MAX) begin
      w_ang_sat = ANG_MAX;
    end else if (w_ang_rnd < ANG_MIN) begin
      w_ang_sat = ANG_MIN;
    end
  end

  // Output register; results hold between valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      angle     <= '0;
      magnitude <= '0;
    end else begin
      out_valid <= w_valid[ITER];
      if (w_valid[ITER]) begin
        if (w_zero) begin
          angle     <= '0;
          magnitude <= '0;
        end else begin
          angle     <= w_ang_sat[ANG_W-1:0];
          magnitude <= w_mag_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring: single vectors, a gapped stream
// against real-valued atan2/sqrt, and a mid-stream reset.
module tb_cordic_vectoring;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic signed [7:0] x_in;
  logic signed [7:0] y_in;
  logic              out_valid;
  logic signed [8:0] angle;
  logic        [8:0] magnitude;

  int checks = 0;
  int errors = 0;

  cordic_vectoring #(
    .ITER (8),
    .IW   (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .angle     (angle),
    .magnitude (magnitude)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic signed [31:0] obs,
                         input int lo, input int hi);
    checks++;
    assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Send one sample, wait (bounded) for its result, check latency and values.
  task automatic send_and_check(input string tag, input int x, input int y,
                                input int a_lo, input int a_hi,
                                input int m_lo, input int m_hi);
    int n;
    x_in     = 8'(x);
    y_in     = 8'(y);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk_eq({tag, "_latency"}, n, 10);
    chk_rng({tag, "_angle"}, angle, a_lo, a_hi);
    chk_rng({tag, "_mag"}, magnitude, m_lo, m_hi);
    step();
  endtask

  int sx [12] = '{100, -50, -120,   10, 127, -128,    0,  33, -60, 90, -100, 40};
  int sy [12] = '{ 20,  70,  -30, -110, 127, -128, -128, -77,  60, -5,    0, 40};

  initial begin
    logic pat [32];
    int   qa [$];
    int   qm [$];
    int   k;
    int   ea;
    int   em;
    logic ev;

    rst      = 1'b1;
    in_valid = 1'b0;
    x_in     = '0;
    y_in     = '0;
    step();
    step();
    chk_eq("reset_valid", out_valid, 0);
    chk_eq("reset_angle", angle, 0);
    chk_eq("reset_mag", magnitude, 0);
    rst = 1'b0;
    step();

    // Directed vectors with hand-computed windows.
    send_and_check("pos_x",    64,   0,   -1,    1,  62,  66);
    send_and_check("pos_y",     0, 127,  100,  101, 125, 129);
    send_and_check("neg_x",  -128,   0,  200,  202, 126, 130);
    send_and_check("q3_diag", -91, -91, -152, -150, 127, 131);
    send_and_check("zero",      0,   0,    0,    0,   0,   0);

    // Twelve samples, two idle cycles after the fifth.
    for (int c = 0; c < 32; c++) pat[c] = (c < 5) || (c >= 7 && c < 14);
    k = 0;
    for (int c = 0; c < 32; c++) begin
      in_valid = pat[c];
      if (pat[c]) begin
        x_in = 8'(sx[k]);
        y_in = 8'(sy[k]);
        qa.push_back(int'($atan2(real'(sy[k]), real'(sx[k])) * 64.0));
        qm.push_back(int'($sqrt(real'(sx[k] * sx[k] + sy[k] * sy[k]))));
        k++;
      end
      step();
      ev = 1'b0;
      if (c >= 9) ev = pat[c-9];
      chk_eq("stream_valid", out_valid, ev);
      if (out_valid === 1'b1 && qa.size() > 0) begin
        ea = qa.pop_front();
        em = qm.pop_front();
        chk_rng("stream_angle", angle, ea - 2, ea + 2);
        chk_rng("stream_mag", magnitude, em - 3, em + 3);
      end
    end
    in_valid = 1'b0;
    chk_eq("stream_drained", qa.size(), 0);

    // Continuous stream with a one-cycle reset on its fourth cycle.
    x_in     = 8'sd64;
    y_in     = 8'sd64;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) step();
    rst = 1'b1;
    step();
    chk_eq("midrst_valid", out_valid, 0);
    chk_eq("midrst_angle", angle, 0);
    chk_eq("midrst_mag", magnitude, 0);
    rst = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      chk_eq("postrst_valid", out_valid, (n == 10) ? 1 : 0);
    end
    chk_rng("postrst_angle", angle, 48, 52);
    chk_rng("postrst_mag", magnitude, 89, 93);
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_vectoring.md
CORDIC_VECTORING -- requirements
Module: cordic_vectoring

Interface
REQ-001 Parameter ITER, default 8, number of micro-rotation stages.
REQ-002 Parameter IW, default 12, internal x/y/z datapath width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  x_in/y_in sampled this cycle.
REQ-006 x_in  input  8  signed Q1.7 vector x component.
REQ-007 y_in  input  8  signed Q1.7 vector y component.
REQ-008 out_valid  output  1  angle/magnitude valid this cycle.
REQ-009 angle  output  9  signed Q3.6 atan2(y,x) in radians, range [-pi, +pi].
REQ-010 magnitude  output  9  unsigned Q2.7 sqrt(x^2+y^2).

Function
REQ-011 The block SHALL be a fully pipelined vectoring-mode CORDIC, the inverse of the sine/cosine rotation pipeline: one new sample accepted per cycle, with no backpressure.
REQ-012 Latency SHALL be exactly ITER+2 cycles from in_valid high to out_valid high: 10 cycles at default.
REQ-013 The pipeline SHALL contain 1 quadrant stage, then ITER micro-rotation stages, then 1 gain/round stage, each registered.
REQ-014 A valid bit SHALL travel with each sample; gaps in in_valid SHALL reappear unchanged on out_valid, and result order SHALL be preserved.
REQ-015 Quadrant stage: sign-extend inputs to IW bits in Q3.8 (input << 1) before any negation, so -128 negates without overflow.
REQ-016 Quadrant stage when x<0 and y>=0: x'=y, y'=-x, z=+pi/2.
REQ-017 Quadrant stage when x<0 and y<0: x'=-y, y'=x, z=-pi/2.
REQ-018 Quadrant stage otherwise: x'=x, y'=y, z=0.
REQ-019 Stage i (0..ITER-1), y>=0: x+=y>>>i, y-=x>>>i, z+=ATAN[i].
REQ-020 Stage i, y<0: x-=y>>>i, y+=x>>>i, z-=ATAN[i].
REQ-021 Each stage SHALL use arithmetic shifts of the previous-stage registered values.
REQ-022 Magnitude SHALL be x_final*INV_GAIN (622, Q0.10 of 0.60725), rounded half-up to Q2.7.
REQ-023 Magnitude SHALL saturate to 511.
REQ-024 Angle SHALL be z_final rounded half-up from Q3.8 to Q3.6.
REQ-025 Angle SHALL saturate to +/-201 (pi).
REQ-026 Input (0,0) SHALL yield angle 0 and magnitude 0.
REQ-027 Input (-128,0) SHALL yield a positive angle (+pi), never -pi.
REQ-028 When out_valid=0, angle and magnitude SHALL hold their last values; they are don't-care to consumers.

Reset
REQ-029 While rst is high at a clock edge, every stage valid bit SHALL clear, and angle and magnitude SHALL be 0.
REQ-030 Samples in flight when reset is asserted SHALL be discarded, and no stale out_valid SHALL follow reset release.
REQ-031 in_valid during a reset cycle SHALL be ignored.
REQ-032 The first sample accepted after release SHALL appear ITER+2 cycles later.

Structure
REQ-033 Shared package cordic_pkg SHALL hold ITER default, IW, ATAN[] table (Q3.8, atan(2^-i)), HALF_PI (402, Q3.8), INV_GAIN (622), and PI_Q36 (201).
REQ-034 One sub-module, cordic_vec_stage, parameterised by stage index, SHALL implement one registered micro-rotation with valid pass-through; it is instantiated ITER times by generate.

Verification
REQ-035 Bench: x=64, y=0 -> angle 0 +/-1 LSB, magnitude 64 +/-2 LSB, after 10 cycles.
REQ-036 Bench: x=0, y=127 -> angle 100..101 (pi/2), magnitude 127 +/-2.
REQ-037 Bench: x=-128, y=0 -> angle 201 +/-1, magnitude 128 +/-2; x=-91, y=-91 -> angle -151 +/-1, magnitude 129 +/-2.
REQ-038 Bench: x=0, y=0 -> angle 0, magnitude 0.
REQ-039 Bench: 12 back-to-back samples with a 2-cycle in_valid gap after the 5th -> out_valid pattern identical and delayed 10 cycles, results in order, each within tolerance of $atan2/$sqrt.
REQ-040 Bench: rst high for 1 cycle at cycle 4 of a full stream -> out_valid low from the next edge until 10 cycles after the first post-reset sample; outputs 0 during reset.
